datapath_bank: RTL and testbench

//  Second-generation accumulator datapath. Adds a bank of NUM_ACC accumulators, an 8-op ALU and Z/N/C/V status flags.

---
 rtl/datapath_pkg.sv | 27 ++
 rtl/mul_seq.sv | 91 +++++++++
 rtl/datapath_bank.sv | 160 ++++++++++++++++
 tb/tb_datapath_bank.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the accumulator-bank datapath: ALU opcodes, acc write-source
// encodings and the multiplier sequencer states.
package datapath_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        SHL = 3'b101,
        SAR = 3'b110,
        MUL = 3'b111
    } alu_op_t;

    localparam logic [1:0] SEL_A_MEM  = 2'b00;
    localparam logic [1:0] SEL_A_EXT  = 2'b01;
    localparam logic [1:0] SEL_A_ALU  = 2'b10;
    localparam logic [1:0] SEL_A_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, a
// one-cycle DONE state presents the full 2*DATA_WIDTH product and its destination.
module mul_seq
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic [IDX_WIDTH-1:0]    i_dest,
    output logic                    o_accept,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [2*DATA_WIDTH-1:0] o_product,
    output logic [IDX_WIDTH-1:0]    o_dest
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

    mul_state_t              r_state;
    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [2*DATA_WIDTH-1:0] r_prod;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [IDX_WIDTH-1:0]    r_dest;
    logic                    r_busy;
    logic                    r_done;

    assign o_accept  = i_start && (r_state == IDLE);
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_prod;
    assign o_dest    = r_dest;

    // busy/done are registered alongside the state so they change exactly on state entry
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_dest   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (o_accept) begin
                        r_mcand  <= {{DATA_WIDTH{1'b0}}, i_a};
                        r_mplier <= i_b;
                        r_prod   <= '0;
                        r_count  <= '0;
                        r_dest   <= i_dest;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/datapath_bank.sv
// Accumulator-bank datapath with 8-op ALU and Z/N/C/V flags.
// Define DATAPATH_BANK_MUL_EN to include the multi-cycle multiplier (mul_seq).
module datapath_bank
    import datapath_pkg::*;
#(
    parameter  int DATA_WIDTH    = 16,
    parameter  int OPERAND_WIDTH = 11,
    parameter  int NUM_ACC       = 4,
    localparam int ACC_SEL_WIDTH = $clog2(NUM_ACC)
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic [OPERAND_WIDTH-1:0] operand_in,
    input  logic [DATA_WIDTH-1:0]    data_memory_in,
    input  logic [ACC_SEL_WIDTH-1:0] acc_sel_in,
    input  logic [2:0]               alu_op_in,
    input  logic [1:0]               sel_A_in,
    input  logic                     sel_B_in,
    input  logic                     acc_wr_in,
    input  logic                     status_wr_in,
    input  logic                     start_in,
    output logic [OPERAND_WIDTH-1:0] data_memory_address_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [DATA_WIDTH-1:0]    ext_out,
    output logic                     status_Z_out,
    output logic                     status_N_out,
    output logic                     status_C_out,
    output logic                     status_V_out,
    output logic                     busy_out,
    output logic                     done_out
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] r_acc [NUM_ACC];
    logic                  r_flagZ, r_flagN, r_flagC, r_flagV;

    alu_op_t               w_op;
    logic [DATA_WIDTH-1:0] w_a, w_b, w_ext, w_muxA, w_aluRes;
    logic [DATA_WIDTH:0]   w_sum;
    logic                  w_aluC, w_aluV;

    logic                    w_mulAccept, w_mulBusy, w_mulDone;
    logic [2*DATA_WIDTH-1:0] w_mulProduct;
    logic [ACC_SEL_WIDTH-1:0] w_mulDest;

    assign w_op  = alu_op_t'(alu_op_in);
    assign w_ext = {{(DATA_WIDTH-OPERAND_WIDTH){operand_in[OPERAND_WIDTH-1]}}, operand_in};
    assign w_a   = r_acc[acc_sel_in];
    assign w_b   = sel_B_in ? w_ext : data_memory_in;

`ifdef DATAPATH_BANK_MUL_EN
    mul_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (ACC_SEL_WIDTH)
    ) u_mulSeq (
        .clock     (clock_in),
        .reset     (reset_in),
        .i_start   (start_in && (w_op == MUL)),
        .i_a       (w_a),
        .i_b       (w_b),
        .i_dest    (acc_sel_in),
        .o_accept  (w_mulAccept),
        .o_busy    (w_mulBusy),
        .o_done    (w_mulDone),
        .o_product (w_mulProduct),
        .o_dest    (w_mulDest)
    );
`else
    logic w_unusedStart;
    assign w_unusedStart = start_in;
    assign w_mulAccept   = 1'b0;
    assign w_mulBusy     = 1'b0;
    assign w_mulDone     = 1'b0;
    assign w_mulProduct  = '0;
    assign w_mulDest     = '0;
`endif

    always_comb begin
        w_aluRes = '0;
        w_aluC   = 1'b0;
        w_aluV   = 1'b0;
        w_sum    = '0;
        case (w_op)
            ADD: begin
                w_sum    = {1'b0, w_a} + {1'b0, w_b};
                w_aluRes = w_sum[MSB:0];
                w_aluC   = w_sum[DATA_WIDTH];
                w_aluV   = (w_a[MSB] == w_b[MSB]) && (w_aluRes[MSB] != w_a[MSB]);
            end
            SUB: begin
                w_aluRes = w_a - w_b;
                w_aluC   = (w_a < w_b);
                w_aluV   = (w_a[MSB] != w_b[MSB]) && (w_aluRes[MSB] != w_a[MSB]);
            end
            AND: w_aluRes = w_a & w_b;
            OR:  w_aluRes = w_a | w_b;
            XOR: w_aluRes = w_a ^ w_b;
            SHL: begin
                w_aluRes = w_a << 1;
                w_aluC   = w_a[MSB];
            end
            SAR: begin
                w_aluRes = $unsigned($signed(w_a) >>> 1);
                w_aluC   = w_a[0];
            end
            MUL:     w_aluRes = w_b;
            default: w_aluRes = '0;
        endcase
    end

    always_comb begin
        w_muxA = data_memory_in;
        case (sel_A_in)
            SEL_A_EXT: w_muxA = w_ext;
            SEL_A_ALU: w_muxA = w_aluRes;
            default:   w_muxA = data_memory_in;
        endcase
    end

    // A finishing multiply owns the write port for its DONE cycle; normal writes stall while busy or starting
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= '0;
            end
            r_flagZ <= 1'b0;
            r_flagN <= 1'b0;
            r_flagC <= 1'b0;
            r_flagV <= 1'b0;
        end else if (w_mulDone) begin
            r_acc[w_mulDest] <= w_mulProduct[MSB:0];
            r_flagZ          <= (w_mulProduct[MSB:0] == '0);
            r_flagN          <= w_mulProduct[MSB];
            r_flagC          <= |w_mulProduct[2*DATA_WIDTH-1:DATA_WIDTH];
            r_flagV          <= 1'b0;
        end else if (!w_mulBusy && !w_mulAccept) begin
            if (acc_wr_in && (sel_A_in != SEL_A_NONE)) begin
                r_acc[acc_sel_in] <= w_muxA;
            end
            if (status_wr_in) begin
                r_flagZ <= (w_aluRes == '0);
                r_flagN <= w_aluRes[MSB];
                r_flagC <= w_aluC;
                r_flagV <= w_aluV;
            end
        end
    end

    assign data_memory_address_out = operand_in;
    assign data_out                = w_a;
    assign ext_out                 = w_ext;
    assign status_Z_out            = r_flagZ;
    assign status_N_out            = r_flagN;
    assign status_C_out            = r_flagC;
    assign status_V_out            = r_flagV;
    assign busy_out                = w_mulBusy;
    assign done_out                = w_mulDone;

endmodule

// File: tb/tb_datapath_bank.sv
// Scoreboard bench for datapath_bank: stimulus queues expected values, a negedge
// monitor pops and compares them; multiply completions are checked against their expected cycle.
module tb_datapath_bank;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic [10:0] operand_in;
    logic [15:0] data_memory_in;
    logic [1:0]  acc_sel_in;
    logic [2:0]  alu_op_in;
    logic [1:0]  sel_A_in;
    logic        sel_B_in;
    logic        acc_wr_in;
    logic        status_wr_in;
    logic        start_in;
    logic [10:0] data_memory_address_out;
    logic [15:0] data_out;
    logic [15:0] ext_out;
    logic        status_Z_out, status_N_out, status_C_out, status_V_out;
    logic        busy_out;
    logic        done_out;

    localparam int K_DATA  = 0;
    localparam int K_FLAGS = 1;
    localparam int K_EXT   = 2;
    localparam int K_ADDR  = 3;
    localparam int K_BUSY  = 4;
    localparam int K_DONE  = 5;

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SAR = 3'b110, OP_MUL = 3'b111;
    localparam logic [1:0] A_MEM = 2'b00, A_EXT = 2'b01, A_ALU = 2'b10, A_NONE = 2'b11;

    int          kindQ[$];
    logic [15:0] valQ[$];
    string       nameQ[$];
    int          mulCycQ[$];
    int          numAssert = 0;
    int          numFail   = 0;
    int          cyc       = 0;

    datapath_bank dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .operand_in              (operand_in),
        .data_memory_in          (data_memory_in),
        .acc_sel_in              (acc_sel_in),
        .alu_op_in               (alu_op_in),
        .sel_A_in                (sel_A_in),
        .sel_B_in                (sel_B_in),
        .acc_wr_in               (acc_wr_in),
        .status_wr_in            (status_wr_in),
        .start_in                (start_in),
        .data_memory_address_out (data_memory_address_out),
        .data_out                (data_out),
        .ext_out                 (ext_out),
        .status_Z_out            (status_Z_out),
        .status_N_out            (status_N_out),
        .status_C_out            (status_C_out),
        .status_V_out            (status_V_out),
        .busy_out                (busy_out),
        .done_out                (done_out)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    function automatic logic [15:0] observe(input int kind);
        case (kind)
            K_DATA:  return data_out;
            K_FLAGS: return {12'b0, status_Z_out, status_N_out, status_C_out, status_V_out};
            K_EXT:   return ext_out;
            K_ADDR:  return {5'b0, data_memory_address_out};
            K_BUSY:  return {15'b0, busy_out};
            K_DONE:  return {15'b0, done_out};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: drains the scoreboard mid-cycle and checks every done pulse against an expected completion
    always @(negedge clock_in) begin
        int          k;
        logic [15:0] v, got;
        string       n;
        int          c;
        while (kindQ.size() > 0) begin
            k   = kindQ.pop_front();
            v   = valQ.pop_front();
            n   = nameQ.pop_front();
            got = observe(k);
            numAssert++;
            if (got !== v) begin
                numFail++;
                $display("[TB] FAIL %s: got %h expected %h", n, got, v);
            end
        end
        if (done_out === 1'b1) begin
            numAssert++;
            if (mulCycQ.size() == 0) begin
                numFail++;
                $display("[TB] FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                c = mulCycQ.pop_front();
                if (cyc != c) begin
                    numFail++;
                    $display("[TB] FAIL done_cycle: got %0d expected %0d", cyc, c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #2;
    endtask

    task automatic checkOutput(input int kind, input logic [15:0] value, input string name);
        kindQ.push_back(kind);
        valQ.push_back(value);
        nameQ.push_back(name);
    endtask

    task automatic idleInputs();
        acc_wr_in    = 1'b0;
        status_wr_in = 1'b0;
        start_in     = 1'b0;
        sel_A_in     = A_NONE;
    endtask

    task automatic applyStimulus(input logic [1:0] accSel, input logic [2:0] op, input logic [1:0] selA,
                                 input logic selB, input logic accWr, input logic statusWr,
                                 input logic start, input logic [15:0] mem, input logic [10:0] operand);
        acc_sel_in     = accSel;
        alu_op_in      = op;
        sel_A_in       = selA;
        sel_B_in       = selB;
        acc_wr_in      = accWr;
        status_wr_in   = statusWr;
        start_in       = start;
        data_memory_in = mem;
        operand_in     = operand;
        tick();
        idleInputs();
    endtask

    task automatic loadAcc(input logic [1:0] idx, input logic [15:0] value);
        applyStimulus(idx, OP_ADD, A_MEM, 1'b0, 1'b1, 1'b0, 1'b0, value, 11'h000);
    endtask

    task automatic readAcc(input logic [1:0] idx, input logic [15:0] value, input string name);
        acc_sel_in = idx;
        checkOutput(K_DATA, value, name);
        tick();
    endtask

    task automatic checkFlags(input logic [3:0] zncv, input string name);
        checkOutput(K_FLAGS, {12'b0, zncv}, name);
        tick();
    endtask

`ifdef DATAPATH_BANK_MUL_EN
    // Launches a multiply into acc[dest] with B from memory; optionally pulses writes/start mid-run
    task automatic runMul(input logic [1:0] dest, input logic [15:0] memB, input bit pulse);
        mulCycQ.push_back(cyc + 17);
        applyStimulus(dest, OP_MUL, A_NONE, 1'b0, 1'b0, 1'b0, 1'b1, memB, 11'h000);
        for (int i = 1; i <= 16; i++) begin
            checkOutput(K_BUSY, 16'h0001, "busy_run");
            if (pulse && i == 5) begin
                applyStimulus(2'd2, OP_MUL, A_MEM, 1'b0, 1'b1, 1'b1, 1'b1, 16'hAAAA, 11'h000);
            end else begin
                tick();
            end
        end
        checkOutput(K_DONE, 16'h0001, "done_pulse");
        checkOutput(K_BUSY, 16'h0000, "busy_in_done");
        tick();
        checkOutput(K_DONE, 16'h0000, "done_cleared");
    endtask
`endif

    initial begin
        reset_in       = 1'b1;
        operand_in     = '0;
        data_memory_in = '0;
        acc_sel_in     = '0;
        alu_op_in      = OP_ADD;
        sel_B_in       = 1'b0;
        idleInputs();
        tick();

        // Reset dominates a simultaneous write
        applyStimulus(2'd0, OP_ADD, A_MEM, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 11'h000);
        checkOutput(K_BUSY, 16'h0000, "reset_busy");
        checkOutput(K_DONE, 16'h0000, "reset_done");
        readAcc(2'd0, 16'h0000, "reset_acc0");
        reset_in = 1'b0;
        checkFlags(4'b0000, "reset_flags");

        loadAcc(2'd2, 16'h1234);
        readAcc(2'd2, 16'h1234, "load_acc2");
        readAcc(2'd0, 16'h0000, "acc0_untouched");
        readAcc(2'd1, 16'h0000, "acc1_untouched");
        readAcc(2'd3, 16'h0000, "acc3_untouched");

        loadAcc(2'd0, 16'h7FFF);
        applyStimulus(2'd0, OP_ADD, A_ALU, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 11'h001);
        readAcc(2'd0, 16'h8000, "add_overflow_acc0");
        checkFlags(4'b0101, "add_overflow_flags");

        loadAcc(2'd1, 16'h0003);
        applyStimulus(2'd1, OP_SUB, A_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 11'h000);
        readAcc(2'd1, 16'hFFFE, "sub_borrow_acc1");
        checkFlags(4'b0110, "sub_borrow_flags");

        loadAcc(2'd1, 16'h0001);
        applyStimulus(2'd1, OP_SHL, A_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 11'h000);
        readAcc(2'd1, 16'h0002, "shl_acc1");
        checkFlags(4'b0000, "shl_flags");
        applyStimulus(2'd1, OP_SAR, A_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 11'h000);
        readAcc(2'd1, 16'h0001, "sar_acc1");
        checkFlags(4'b0000, "sar_flags");
        loadAcc(2'd1, 16'h8001);
        applyStimulus(2'd1, OP_SAR, A_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 11'h000);
        readAcc(2'd1, 16'hC000, "sar_neg_acc1");
        checkFlags(4'b0110, "sar_neg_flags");
        applyStimulus(2'd0, OP_SHL, A_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 11'h000);
        readAcc(2'd0, 16'h0000, "shl_msb_acc0");
        checkFlags(4'b1010, "shl_msb_flags");

        loadAcc(2'd3, 16'hF0F0);
        applyStimulus(2'd3, OP_AND, A_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0FF0, 11'h000);
        readAcc(2'd3, 16'h00F0, "and_acc3");
        checkFlags(4'b0000, "and_flags");
        applyStimulus(2'd3, OP_XOR, A_ALU, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00F0, 11'h000);
        readAcc(2'd3, 16'h0000, "xor_acc3");
        checkFlags(4'b1000, "xor_flags");
        applyStimulus(2'd3, OP_OR, A_ALU, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 11'h7FF);
        readAcc(2'd3, 16'hFFFF, "or_ext_acc3");
        checkFlags(4'b0100, "or_flags");
        applyStimulus(2'd3, OP_ADD, A_ALU, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 11'h000);
        readAcc(2'd3, 16'h0000, "add_nostatus_acc3");
        checkFlags(4'b0100, "flags_held");

        applyStimulus(2'd2, OP_MUL, A_ALU, 1'b1, 1'b1, 1'b1, 1'b0, 16'h9999, 11'h001);
        readAcc(2'd2, 16'h0001, "mul_passthrough_acc2");
        checkFlags(4'b0000, "mul_passthrough_flags");

        operand_in = 11'h400;
        checkOutput(K_EXT, 16'hFC00, "ext_negative");
        checkOutput(K_ADDR, 16'h0400, "mem_address");
        tick();
        operand_in = 11'h3FF;
        checkOutput(K_EXT, 16'h03FF, "ext_positive");
        tick();

`ifdef DATAPATH_BANK_MUL_EN
        loadAcc(2'd3, 16'h00FF);
        runMul(2'd3, 16'h0101, 1'b0);
        readAcc(2'd3, 16'hFFFF, "mul_acc3");
        checkFlags(4'b0100, "mul_flags");

        loadAcc(2'd3, 16'h1000);
        runMul(2'd3, 16'h0010, 1'b1);
        readAcc(2'd3, 16'h0000, "mul_carry_acc3");
        checkFlags(4'b1010, "mul_carry_flags");
        readAcc(2'd2, 16'h0001, "midrun_write_blocked");

        loadAcc(2'd3, 16'h0003);
        applyStimulus(2'd3, OP_MUL, A_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 11'h000);
        repeat (4) tick();
        checkOutput(K_BUSY, 16'h0001, "busy_before_abort");
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        checkOutput(K_BUSY, 16'h0000, "busy_after_abort");
        repeat (20) tick();
        readAcc(2'd2, 16'h0000, "abort_acc2");
        readAcc(2'd3, 16'h0000, "abort_acc3");
        checkFlags(4'b0000, "abort_flags");
`else
        applyStimulus(2'd2, OP_MUL, A_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5555, 11'h000);
        checkOutput(K_BUSY, 16'h0000, "no_mul_busy");
        checkOutput(K_DONE, 16'h0000, "no_mul_done");
        readAcc(2'd2, 16'h5555, "no_mul_write");
        repeat (18) begin
            checkOutput(K_BUSY, 16'h0000, "no_mul_busy_later");
            tick();
        end
`endif

        tick();
        numAssert++;
        if (kindQ.size() != 0 || mulCycQ.size() != 0) begin
            numFail++;
            $display("[TB] FAIL drain: got %0d/%0d pending expected 0/0", kindQ.size(), mulCycQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", numAssert, numFail);
        $finish;
    end

endmodule
